// File: rtl/pipe_regfile_if.sv
// Bundle for the scoreboarded register file: read ports, issue, write-back and cancel.
// The register-file side uses the slave modport; the core side uses master.
interface pipe_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              cnl_valid;
  logic [ADDR_W-1:0] cnl_rd;
  logic              err_underflow;

  modport master (
    output rs_addr, rt_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, cnl_valid, cnl_rd,
    input  rs_data, rt_data, rs_busy, rt_busy, iss_ready, err_underflow
  );

  modport slave (
    input  rs_addr, rt_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, cnl_valid, cnl_rd,
    output rs_data, rt_data, rs_busy, rt_busy, iss_ready, err_underflow
  );
endinterface

// File: rtl/pipe_regfile.sv
// Two-read/one-write register file with a per-register pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write-back data and retire onto the read ports.
module pipe_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic              clk,
  input logic              rst_n,
  pipe_regfile_if.slave    rf
);
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [CNT_W-1:0]  pend_q [Depth];
  logic [CNT_W-1:0]  pend_d [Depth];
  logic              err_q, err_d;
  logic              iss_ready;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign iss_ready = (pend_q[rf.iss_rd] != CntMax) || is_zero(rf.iss_rd);
  assign rf.iss_ready = iss_ready;
  assign rf.err_underflow = err_q;

`ifdef RF_BYPASS_EN
  logic rs_hit, rt_hit;
  assign rs_hit = rf.wb_valid && (rf.wb_addr == rf.rs_addr) && !is_zero(rf.rs_addr);
  assign rt_hit = rf.wb_valid && (rf.wb_addr == rf.rt_addr) && !is_zero(rf.rt_addr);
  assign rf.rs_data = is_zero(rf.rs_addr) ? '0 : (rs_hit ? rf.wb_data : regs_q[rf.rs_addr]);
  assign rf.rt_data = is_zero(rf.rt_addr) ? '0 : (rt_hit ? rf.wb_data : regs_q[rf.rt_addr]);
  // Busy sees the count after this cycle's retire; a count of 0 with a hit stays not-busy.
  assign rf.rs_busy = pend_q[rf.rs_addr] > CNT_W'(rs_hit);
  assign rf.rt_busy = pend_q[rf.rt_addr] > CNT_W'(rt_hit);
`else
  assign rf.rs_data = is_zero(rf.rs_addr) ? '0 : regs_q[rf.rs_addr];
  assign rf.rt_data = is_zero(rf.rt_addr) ? '0 : regs_q[rf.rt_addr];
  assign rf.rs_busy = pend_q[rf.rs_addr] != '0;
  assign rf.rt_busy = pend_q[rf.rt_addr] != '0;
`endif

  always_comb begin
    regs_d = regs_q;
    if (rf.wb_valid && !is_zero(rf.wb_addr)) begin
      regs_d[rf.wb_addr] = rf.wb_data;
    end
  end

  logic [ADDR_W-1:0] ra;
  logic              inc;
  logic [1:0]        dec;
  logic [CNT_W:0]    sum;

  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    ra     = '0;
    inc    = 1'b0;
    dec    = '0;
    sum    = '0;
    for (int unsigned r = 0; r < Depth; r++) begin
      ra  = ADDR_W'(r);
      inc = rf.iss_valid && iss_ready && (rf.iss_rd == ra);
      dec = {1'b0, rf.wb_valid && (rf.wb_addr == ra)} + {1'b0, rf.cnl_valid && (rf.cnl_rd == ra)};
      // The issue is counted before any retire/cancel, so it can absorb one decrement.
      sum = {1'b0, pend_q[r]} + {{CNT_W{1'b0}}, inc};
      if (is_zero(ra)) begin
        pend_d[r] = '0;
      end else if (sum < (CNT_W + 1)'(dec)) begin
        pend_d[r] = '0;
        err_d     = 1'b1;
      end else begin
        pend_d[r] = CNT_W'(sum - (CNT_W + 1)'(dec));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end
endmodule
